// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared types and helpers for the round-robin one-hot select arbiter.
package rr_decoder_arbiter_pkg;

  localparam int RR_N_REQ = 4;
  localparam int RR_IDX_W = $clog2(RR_N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [RR_N_REQ-1:0] onehot(input logic [RR_IDX_W-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_decoder_arbiter_pick.sv
// Combinational circular first-one finder: scans req starting just after
// last_ptr and wrapping, so the previous winner is examined last.
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_ptr,
  output logic [IDX_W-1:0] sel,
  output logic             any
);

  logic [IDX_W:0] sum;

  // Walk offsets from far to near so the nearest set bit is the last writer.
  always_comb begin
    sel = '0;
    any = 1'b0;
    sum = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      sum = {1'b0, last_ptr} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(N_REQ)) begin
        sum = sum - (IDX_W+1)'(N_REQ);
      end
      if (req[sum[IDX_W-1:0]]) begin
        sel = sum[IDX_W-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter driving a shared one-hot select: registered grant,
// enable gating, per-grant hold limit and a mandatory idle turnaround cycle.
module rr_decoder_arbiter
  import rr_decoder_arbiter_pkg::*;
#(
  parameter int N_REQ    = RR_N_REQ,
  parameter int MAX_HOLD = 8,
  localparam int CNT_W   = $clog2(MAX_HOLD),
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_id,
  output logic             grant_valid,
  output logic             timeout
);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [IDX_W-1:0] last_ptr;
  logic [IDX_W-1:0] sel;
  logic             any;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (req),
    .last_ptr (last_ptr),
    .sel      (sel),
    .any      (any)
  );

  // Decision priority in BUSY: enable loss, then release, then hold limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      last_ptr    <= IDX_W'(N_REQ - 1);
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && any) begin
            grant       <= onehot(sel);
            grant_id    <= sel;
            grant_valid <= 1'b1;
            last_ptr    <= sel;
            hold_cnt    <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (!enable) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            state       <= IDLE;
          end else if (!req[grant_id]) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            state       <= GAP;
          end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
            state       <= GAP;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          grant       <= '0;
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Round-robin arbiter that shares a single one-hot select resource (2-to-4 decode) among 4 requesters.
- Produces a registered one-hot grant plus its binary index.
- Honours a global enable: no grant is ever driven while enable=0.
- Enforces a maximum hold time per grant.
- Sits between requesting agents and the shared one-hot-selected datapath; it is the sole driver of that datapath's select lines.

Parameters:
- N_REQ, 4, number of requesters; the one-hot grant width. Design and verification target 4.
- MAX_HOLD, 8, maximum consecutive cycles a grant may be held before forced revocation. Must be ≥2.
- CNT_W, $clog2(MAX_HOLD), hold-counter width. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  global enable. 0 forces grant to 0 and blocks arbitration.
- req  input  N_REQ  request vector. A requester holds its bit high for the whole transaction.
- grant  output  N_REQ  registered one-hot grant. All zeros when no grant.
- grant_id  output  $clog2(N_REQ)  binary index of the granted requester. Valid only when grant_valid=1.
- grant_valid  output  1  equals |grant, registered.
- timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Behaviour:
- Reset (async, active-high) values:
  - grant=0, grant_id=0, grant_valid=0, timeout=0.
  - state=IDLE, hold_cnt=0, last_ptr=N_REQ-1, so requester 0 has first priority.
- States: IDLE, BUSY, GAP.
- IDLE:
  - If enable=1 and req≠0, select the first set req bit scanning circularly from last_ptr+1.
  - Next edge: grant=onehot(sel), grant_id=sel, grant_valid=1, last_ptr=sel, hold_cnt=0, state→BUSY.
  - Latency from req sampled high to grant high is 1 cycle.
  - Otherwise remain in IDLE with grant=0.
- BUSY (evaluated in priority order each edge):
  - enable=0: grant=0 next edge, state→IDLE, timeout=0. last_ptr keeps the revoked id.
  - req[grant_id]=0 (release): grant=0 next edge, state→GAP.
  - hold_cnt==MAX_HOLD-1: grant=0, timeout=1 for exactly one cycle, state→GAP.
  - Otherwise: hold_cnt increments and grant holds.
  - Consequence: a grant stays high for at most MAX_HOLD cycles.
- GAP:
  - One mandatory turnaround cycle with grant=0. The shared select is never switched directly between two requesters.
  - Then →IDLE; arbitration happens in IDLE on the following edge.
  - Minimum spacing between grants is therefore 2 zero cycles after release or timeout.
- Simultaneous events:
  - Release and hold limit on the same cycle: release wins, timeout=0.
  - enable=0 overrides both release and timeout.
- Invariants:
  - grant is always zero or exactly one-hot.
  - grant=0 on every cycle in which enable was 0 at the preceding edge. This is the required fix for decoders that ignore enable.
- Fairness:
  - A requester that was just granted has lowest priority at the next arbitration.
  - With all 4 requesting continuously, the grant order is 0,1,2,3,0,…
- Reset mid-grant: grant drops asynchronously on rst assertion; priority restarts at requester 0.
- req bits of non-granted requesters may change freely during BUSY without effect.

Decomposition:
- Shared package: state enum typedef (IDLE, BUSY, GAP), N_REQ default, and the one-hot helper function onehot(idx).
- One natural sub-module: rr_priority_pick. Combinational circular first-one finder taking (req, last_ptr) and returning (sel, any). It is reusable by other arbiters.
- FSM, hold counter and output registers live in the top module.

Test Plan:
- Reset then enable=1, req=4'b0100 → grant=4'b0100, grant_id=2, grant_valid=1 one cycle later. Drop req[2] → grant=0 next cycle; GAP observed.
- enable=1, req=4'b1111 held, each granted requester releases after 2 cycles → grant sequence 0001,0010,0100,1000,0001, with two zero cycles between grants.
- req=4'b0001 held forever, MAX_HOLD=8 → grant high exactly 8 cycles, timeout=1 on the revocation cycle only. Re-grant to requester 0 after GAP because it is the only requester.
- In BUSY with grant=4'b0010, drop enable → grant=0 next cycle, timeout=0. Keep enable=0 with req=4'b1111 for 5 cycles → grant stays 0. Raise enable → grant=4'b0100.
- Release on the same cycle that hold_cnt reaches 7 → grant drops, timeout stays 0.
- Assert rst asynchronously mid-BUSY (grant=4'b1000) → grant=0 immediately. After release of rst with req=4'b1111 → first grant is 4'b0001.
